// File: rtl/sw_field_decoder_pkg.sv
// Shared definitions for the switch-field decoder.
//   MODE_*      : values of the 2-bit mode field (top two switch bits)
//   deb_state_t : debounce FSM state encoding
package sw_dec_pkg;

  localparam logic [1:0] MODE_LOW  = 2'b00;
  localparam logic [1:0] MODE_HIGH = 2'b01;
  localparam logic [1:0] MODE_CAT  = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_UPDATE = 2'd2
  } deb_state_t;

endpackage

// File: rtl/sw_debounce.sv
// Synchroniser plus stability filter for a raw switch bank.
// Ports:
//   clk           in   1  system clock
//   rst           in   1  asynchronous active-high reset
//   sw            in   W  raw switches, asynchronous to clk
//   stable_vec    out  W  switch value that passed the stability filter
//   stable_strobe out  1  one-cycle pulse when stable_vec has been refreshed
//   busy          out  1  FSM is not idle
//
// state     | meaning
// ST_IDLE   | waiting for the synchronised bank to differ from sw_last
// ST_SETTLE | counting consecutive cycles with sw_s == sw_last
// ST_UPDATE | value accepted; publish it and return to idle
module sw_debounce
  import sw_dec_pkg::*;
#(
  parameter int W          = 10,
  parameter int DEB_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] sw,
  output logic [W-1:0] stable_vec,
  output logic         stable_strobe,
  output logic         busy
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  deb_state_t     state, state_nxt;
  logic [W-1:0]   sync1, sw_s;
  logic [W-1:0]   sw_last, sw_last_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic           publish;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic, including the sw_last / counter updates that go with it
  always_comb begin
    state_nxt   = state;
    sw_last_nxt = sw_last;
    cnt_nxt     = cnt;
    case (state)
      ST_IDLE: begin
        if (sw_s != sw_last) begin
          sw_last_nxt = sw_s;
          cnt_nxt     = '0;
          state_nxt   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (sw_s != sw_last) begin
          // glitch: restart the stability window on the new value
          sw_last_nxt = sw_s;
          cnt_nxt     = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_UPDATE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_UPDATE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy    = (state != ST_IDLE);
    publish = (state == ST_UPDATE);
  end

  // Synchroniser, filter datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1         <= '0;
      sw_s          <= '0;
      sw_last       <= '0;
      cnt           <= '0;
      stable_vec    <= '0;
      stable_strobe <= 1'b0;
    end else begin
      sync1         <= sw;
      sw_s          <= sync1;
      sw_last       <= sw_last_nxt;
      cnt           <= cnt_nxt;
      stable_strobe <= publish;
      if (publish) stable_vec <= sw_last;
    end
  end

endmodule

// File: rtl/sw_field_decoder.sv
// Debounced switch-field decoder driving a board-level result bus.
// Ports:
//   clk     in   1      system clock
//   rst     in   1      asynchronous active-high reset
//   sw      in   SW_W   raw switch bank
//   rez     out  OUT_W  registered decoded result
//   upd     out  1      one-cycle pulse when rez takes a new, different value
//   mode_o  out  2      mode applied at the last update
//   busy    out  1      debounce FSM not idle
module sw_field_decoder
  import sw_dec_pkg::*;
#(
  parameter int SW_W       = 10,
  parameter int FIELD_W    = 4,
  parameter int OUT_W      = 8,
  parameter int DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SW_W-1:0]  sw,
  output logic [OUT_W-1:0] rez,
  output logic             upd,
  output logic [1:0]       mode_o,
  output logic             busy
);

  localparam int WIDE_W = 2 * FIELD_W;

  logic [SW_W-1:0]    stable_vec;
  logic               stable_strobe;
  logic [1:0]         mode;
  logic [FIELD_W-1:0] f0, f1;
  logic [WIDE_W-1:0]  wide;
  logic [OUT_W-1:0]   rez_nxt;

  sw_debounce #(
    .W          (SW_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk           (clk),
    .rst           (rst),
    .sw            (sw),
    .stable_vec    (stable_vec),
    .stable_strobe (stable_strobe),
    .busy          (busy)
  );

  assign mode = stable_vec[SW_W-1 -: 2];
  assign f0   = stable_vec[FIELD_W-1:0];
  assign f1   = stable_vec[WIDE_W-1:FIELD_W];

  always_comb begin
    wide = '0;
    case (mode)
      MODE_LOW:  wide = {{FIELD_W{1'b0}}, f0};
      MODE_HIGH: wide = {f1, {FIELD_W{1'b0}}};
      MODE_CAT:  wide = {f1, f0};
      default:   wide = '0;
    endcase
  end

  // Decode is done at 2*FIELD_W bits, then fitted to the bus width
  generate
    if (OUT_W > WIDE_W) begin : g_ext
      assign rez_nxt = {{(OUT_W-WIDE_W){1'b0}}, wide};
    end else if (OUT_W == WIDE_W) begin : g_eq
      assign rez_nxt = wide;
    end else begin : g_trunc
      assign rez_nxt = wide[OUT_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rez    <= '0;
      upd    <= 1'b0;
      mode_o <= MODE_LOW;
    end else begin
      upd <= 1'b0;
      if (stable_strobe) begin
        mode_o <= mode;
        if (mode != MODE_HOLD) begin
          rez <= rez_nxt;
          upd <= (rez_nxt != rez);
        end
      end
    end
  end

endmodule

// File: tb/tb_sw_field_decoder.sv
module tb_sw_field_decoder;

  localparam int LAT = 4 + 4; // DEB_CYCLES + 4

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] sw  = '0;
  logic [7:0] rez;
  logic       upd;
  logic [1:0] mode_o;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int upd_cnt = 0;
  logic [7:0] sb_q[$];

  typedef struct {
    logic [9:0] sw;
    logic [7:0] rez;
    logic       upd;
    logic [1:0] mode;
  } vec_t;

  vec_t vecs[9];

  sw_field_decoder #(
    .SW_W(10), .FIELD_W(4), .OUT_W(8), .DEB_CYCLES(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sw     (sw),
    .rez    (rez),
    .upd    (upd),
    .mode_o (mode_o),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every upd pulse pops one expected rez value
  always @(posedge clk) begin
    #1;
    if (upd === 1'b1) begin
      upd_cnt++;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_upd", 32'(rez), 32'hFFFF_FFFF);
      end else begin
        chk("sb_rez", 32'(rez), 32'(sb_q.pop_front()));
      end
    end
  end

  // Drive sw at a falling edge; the next rising edge is edge 0
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    sw = v.sw;
    if (v.upd) sb_q.push_back(v.rez);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_busy_mid"}, 32'(busy), 32'd1);
    repeat (LAT - 4) @(posedge clk);
    #1;
    chk({tag, "_upd_early"}, 32'(upd), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_rez"},  32'(rez),    32'(v.rez));
    chk({tag, "_upd"},  32'(upd),    32'(v.upd));
    chk({tag, "_mode"}, 32'(mode_o), 32'(v.mode));
    chk({tag, "_busy"}, 32'(busy),   32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_upd_once"}, 32'(upd), 32'd0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int upd_before;

    vecs[0] = '{10'h00A, 8'd10,  1'b1, 2'b00};
    vecs[1] = '{10'h170, 8'd112, 1'b1, 2'b01};
    vecs[2] = '{10'h2FF, 8'd255, 1'b1, 2'b10};
    vecs[3] = '{10'h00A, 8'd10,  1'b1, 2'b00};
    vecs[4] = '{10'h303, 8'd10,  1'b0, 2'b11}; // hold
    vecs[5] = '{10'h00A, 8'd10,  1'b0, 2'b00}; // same value re-decoded
    vecs[6] = '{10'h10A, 8'd0,   1'b1, 2'b01};
    vecs[7] = '{10'h105, 8'd0,   1'b0, 2'b01}; // only the ignored F0 changed
    vecs[8] = '{10'h2A5, 8'd165, 1'b1, 2'b10};

    #12;
    chk("reset_rez",  32'(rez),    32'd0);
    chk("reset_upd",  32'(upd),    32'd0);
    chk("reset_mode", 32'(mode_o), 32'd0);
    chk("reset_busy", 32'(busy),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Bounce: toggle sw[0] every 2 cycles, settle on F0=5
    upd_before = upd_cnt;
    for (int i = 0; i < 10; i++) begin
      repeat (2) @(negedge clk);
      if (i == 9) begin
        chk("bounce_busy", 32'(busy), 32'd1);
        sb_q.push_back(8'd5);
      end
      sw = (i % 2 == 0) ? 10'h004 : 10'h005;
    end
    chk("bounce_no_upd", 32'(upd_cnt), 32'(upd_before));
    repeat (LAT) @(posedge clk);
    #1;
    chk("bounce_upd_early", 32'(upd), 32'd0);
    chk("bounce_rez_hold",  32'(rez), 32'd165);
    @(posedge clk);
    #1;
    chk("bounce_rez", 32'(rez), 32'd5);
    chk("bounce_upd", 32'(upd), 32'd1);
    repeat (3) @(posedge clk);
    chk("bounce_one_upd", 32'(upd_cnt), 32'(upd_before + 1));

    // Reset in the middle of SETTLE with a mode-11 bank
    @(negedge clk);
    sw = 10'h3FF;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_rez",  32'(rez),    32'd0);
    chk("rst_mid_upd",  32'(upd),    32'd0);
    chk("rst_mid_busy0", 32'(busy),  32'd0);
    chk("rst_mid_mode", 32'(mode_o), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #1;
    chk("rst_after_rez",  32'(rez),    32'd0);
    chk("rst_after_mode", 32'(mode_o), 32'd3);
    chk("rst_after_upd",  32'(upd),    32'd0);
    chk("rst_after_busy", 32'(busy),   32'd0);

    repeat (2) @(posedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
